// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage Y86-64 core: stall/bubble generation, run-state
// sequencing (IDLE/RUN/MEMWAIT/HALT), CC-write gating and cycle/retired-instruction counters.
module pipe_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic [3:0]       E_icode_i,
  input  logic [3:0]       E_dstM_i,
  input  logic             e_cnd_i,
  input  logic [3:0]       M_icode_i,
  input  logic [2:0]       m_stat_i,
  input  logic [3:0]       W_icode_i,
  input  logic [2:0]       W_stat_i,
  input  logic             dmem_ready_i,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             E_stall_o,
  output logic             M_stall_o,
  output logic             W_stall_o,
  output logic             D_bubble_o,
  output logic             E_bubble_o,
  output logic             M_bubble_o,
  output logic             set_cc_o,
  output logic [1:0]       state_o,
  output logic [2:0]       halt_stat_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] MEMWAIT = 2'd2;
  localparam logic [1:0] HALT    = 2'd3;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  function automatic logic isExc(input logic [2:0] s);
    return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
  endfunction

  logic [1:0]        state, nextState;
  logic [2:0]        haltStat, nextHaltStat;
  logic [WAIT_W-1:0] waitCnt, nextWaitCnt;
  logic [CNT_W-1:0]  cycleCnt, instrCnt;

  logic loadUse, retHazard, mispredict, memOp, mExc, wExc;

  always_comb begin
    loadUse    = ((E_icode_i == I_MRMOVQ) || (E_icode_i == I_POPQ)) && (E_dstM_i != R_NONE) &&
                 ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    retHazard  = (D_icode_i == I_RET) || (E_icode_i == I_RET) || (M_icode_i == I_RET);
    mispredict = (E_icode_i == I_JXX) && !e_cnd_i;
    memOp      = (M_icode_i == I_RMMOVQ) || (M_icode_i == I_MRMOVQ) || (M_icode_i == I_CALL) ||
                 (M_icode_i == I_RET) || (M_icode_i == I_PUSHQ) || (M_icode_i == I_POPQ);
    mExc       = isExc(m_stat_i);
    wExc       = isExc(W_stat_i);
  end

  // Per-state output decode; within RUN a stalled stage never also takes a bubble.
  always_comb begin
    F_stall_o  = 1'b0;
    D_stall_o  = 1'b0;
    E_stall_o  = 1'b0;
    M_stall_o  = 1'b0;
    W_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_bubble_o = 1'b0;
    M_bubble_o = 1'b0;
    set_cc_o   = 1'b0;
    case (state)
      IDLE: begin
        F_stall_o  = 1'b1;
        W_stall_o  = 1'b1;
        D_bubble_o = 1'b1;
        E_bubble_o = 1'b1;
        M_bubble_o = 1'b1;
      end
      RUN: begin
        F_stall_o  = loadUse | retHazard;
        D_stall_o  = loadUse;
        W_stall_o  = wExc;
        D_bubble_o = (mispredict | (!loadUse & retHazard)) & !loadUse;
        E_bubble_o = mispredict | loadUse;
        M_bubble_o = mExc | wExc;
        set_cc_o   = (E_icode_i == I_OPQ) & !mExc & !wExc;
      end
      default: begin
        F_stall_o = 1'b1;
        D_stall_o = 1'b1;
        E_stall_o = 1'b1;
        M_stall_o = 1'b1;
        W_stall_o = 1'b1;
      end
    endcase
  end

  // dmem_ready_i is a completion strobe: a memory-stage access finishes in the cycle it is high.
  always_comb begin
    nextState    = state;
    nextHaltStat = haltStat;
    nextWaitCnt  = waitCnt;
    case (state)
      IDLE: begin
        if (start_i) nextState = RUN;
      end
      RUN: begin
        if (wExc) begin
          nextState    = HALT;
          nextHaltStat = W_stat_i;
        end else if (memOp && !dmem_ready_i) begin
          nextState   = MEMWAIT;
          nextWaitCnt = '0;
        end
      end
      MEMWAIT: begin
        if (dmem_ready_i) begin
          nextState = RUN;
        end else if (waitCnt == WAIT_LAST) begin
          nextState    = HALT;
          nextHaltStat = S_ADR;
        end else begin
          nextWaitCnt = waitCnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      haltStat <= 3'd0;
      waitCnt  <= '0;
      cycleCnt <= '0;
      instrCnt <= '0;
    end else begin
      state    <= nextState;
      haltStat <= nextHaltStat;
      waitCnt  <= nextWaitCnt;
      if (state == RUN || state == MEMWAIT) cycleCnt <= cycleCnt + 1'b1;
      if (state == RUN && !W_stall_o && W_icode_i != I_NOP && W_stat_i == S_AOK)
        instrCnt <= instrCnt + 1'b1;
    end
  end

  assign state_o     = state;
  assign halt_stat_o = haltStat;
  assign cycle_cnt_o = cycleCnt;
  assign instr_cnt_o = instrCnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver pushes hand-computed expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_MW   = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  // stalls packed {F,D,E,M,W}, bubbles packed {D,E,M}
  localparam logic [4:0] STL_NONE = 5'b00000;
  localparam logic [4:0] STL_ALL  = 5'b11111;
  localparam logic [4:0] STL_IDLE = 5'b10001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
  logic e_cnd, dmem_ready;
  logic [2:0] m_stat, W_stat;

  logic F_stall, D_stall, E_stall, M_stall, W_stall;
  logic D_bubble, E_bubble, M_bubble, set_cc;
  logic [1:0] state;
  logic [2:0] halt_stat;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  pipe_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
    .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_cnd_i(e_cnd),
    .M_icode_i(M_icode), .m_stat_i(m_stat), .W_icode_i(W_icode), .W_stat_i(W_stat),
    .dmem_ready_i(dmem_ready),
    .F_stall_o(F_stall), .D_stall_o(D_stall), .E_stall_o(E_stall), .M_stall_o(M_stall),
    .W_stall_o(W_stall), .D_bubble_o(D_bubble), .E_bubble_o(E_bubble), .M_bubble_o(M_bubble),
    .set_cc_o(set_cc), .state_o(state), .halt_stat_o(halt_stat),
    .cycle_cnt_o(cycle_cnt), .instr_cnt_o(instr_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard
  localparam int W = 2 + 3 + 5 + 3 + 1 + 2 * CNT_W;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [W-1:0] obs;
  int n_checks = 0;
  int n_pass   = 0;

  assign obs = {state, halt_stat, F_stall, D_stall, E_stall, M_stall, W_stall,
                D_bubble, E_bubble, M_bubble, set_cc, cycle_cnt, instr_cnt};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (obs === e) n_pass++;
      else $display("FAIL %s: got st=%0d hs=%0d stl=%b bub=%b cc=%b cyc=%0d ins=%0d, expected st=%0d hs=%0d stl=%b bub=%b cc=%b cyc=%0d ins=%0d",
                    nm, obs[W-1 -: 2], obs[W-3 -: 3], obs[W-6 -: 5], obs[W-11 -: 3], obs[2*CNT_W],
                    obs[2*CNT_W-1 -: CNT_W], obs[CNT_W-1:0],
                    e[W-1 -: 2], e[W-3 -: 3], e[W-6 -: 5], e[W-11 -: 3], e[2*CNT_W],
                    e[2*CNT_W-1 -: CNT_W], e[CNT_W-1:0]);
    end
  end

  // expected counters, advanced from the expected state of each cycle
  logic [CNT_W-1:0] cyc_m, ins_m;

  // driver tasks
  task automatic nop_inputs();
    start = 1'b0; D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
    E_icode = 4'h1; E_dstM = 4'hF; e_cnd = 1'b1; M_icode = 4'h1; m_stat = 3'd1;
    W_icode = 4'h1; W_stat = 3'd1; dmem_ready = 1'b1;
  endtask

  task automatic step(input string nm, input logic [1:0] st, input logic [2:0] hs,
                      input logic [4:0] stl, input logic [2:0] bub, input logic cc);
    exp_q.push_back({st, hs, stl, bub, cc, cyc_m, ins_m});
    name_q.push_back(nm);
    @(posedge clk);
    if (rst) begin
      cyc_m = '0;
      ins_m = '0;
    end else begin
      if (st == S_RUN || st == S_MW) cyc_m = cyc_m + 1'b1;
      if (st == S_RUN && !stl[0] && W_icode != 4'h1 && W_stat == 3'd1) ins_m = ins_m + 1'b1;
    end
    #1;
  endtask

  task automatic do_reset_and_start();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cyc_m = '0; ins_m = '0;
    start = 1'b1;
    step("start_idle", S_IDLE, 3'd0, STL_IDLE, 3'b111, 1'b0);
    start = 1'b0;
  endtask

  initial begin
    nop_inputs();
    cyc_m = '0; ins_m = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state held without start
    for (int i = 0; i < 5; i++) step("idle_reset", S_IDLE, 3'd0, STL_IDLE, 3'b111, 1'b0);
    start = 1'b1;
    step("idle_start", S_IDLE, 3'd0, STL_IDLE, 3'b111, 1'b0);
    start = 1'b0;
    step("run_nop", S_RUN, 3'd0, STL_NONE, 3'b000, 1'b0);

    // load/use
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    step("lu_srcA", S_RUN, 3'd0, 5'b11000, 3'b010, 1'b0);
    E_icode = 4'hB; E_dstM = 4'h4; d_srcA = 4'hF; d_srcB = 4'h4;
    step("lu_popq_srcB", S_RUN, 3'd0, 5'b11000, 3'b010, 1'b0);
    E_icode = 4'h5; E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
    step("lu_none_reg", S_RUN, 3'd0, STL_NONE, 3'b000, 1'b0);
    nop_inputs();

    // mispredict and ret
    E_icode = 4'h7; e_cnd = 1'b0;
    step("mispredict", S_RUN, 3'd0, STL_NONE, 3'b110, 1'b0);
    D_icode = 4'h9;
    step("mp_plus_ret", S_RUN, 3'd0, 5'b10000, 3'b110, 1'b0);
    e_cnd = 1'b1;
    step("ret_taken_jxx", S_RUN, 3'd0, 5'b10000, 3'b100, 1'b0);
    nop_inputs();

    // CC gating
    E_icode = 4'h6;
    step("opq_setcc", S_RUN, 3'd0, STL_NONE, 3'b000, 1'b1);
    m_stat = 3'd4;
    step("opq_mexc", S_RUN, 3'd0, STL_NONE, 3'b001, 1'b0);
    nop_inputs();

    // memory wait, three MEMWAIT cycles
    M_icode = 4'h5; dmem_ready = 1'b0;
    step("mem_miss", S_RUN, 3'd0, STL_NONE, 3'b000, 1'b0);
    step("memwait1", S_MW, 3'd0, STL_ALL, 3'b000, 1'b0);
    step("memwait2", S_MW, 3'd0, STL_ALL, 3'b000, 1'b0);
    dmem_ready = 1'b1; M_icode = 4'h1;
    step("memwait3", S_MW, 3'd0, STL_ALL, 3'b000, 1'b0);
    step("mem_resume", S_RUN, 3'd0, STL_NONE, 3'b000, 1'b0);

    // memory timeout -> HALT with ADR
    M_icode = 4'hB; dmem_ready = 1'b0;
    step("to_miss", S_RUN, 3'd0, STL_NONE, 3'b000, 1'b0);
    for (int i = 0; i < 16; i++) step("to_memwait", S_MW, 3'd0, STL_ALL, 3'b000, 1'b0);
    nop_inputs();
    start = 1'b1;
    step("halt_adr", S_HALT, 3'd3, STL_ALL, 3'b000, 1'b0);
    step("halt_ign_start", S_HALT, 3'd3, STL_ALL, 3'b000, 1'b0);
    rst = 1'b1; start = 1'b0;
    step("halt_rst", S_HALT, 3'd3, STL_ALL, 3'b000, 1'b0);
    rst = 1'b0;
    step("rst_from_halt", S_IDLE, 3'd0, STL_IDLE, 3'b111, 1'b0);

    // W exception beats MEMWAIT entry
    start = 1'b1;
    step("restart", S_IDLE, 3'd0, STL_IDLE, 3'b111, 1'b0);
    start = 1'b0;
    W_stat = 3'd2; W_icode = 4'h6; M_icode = 4'h5; dmem_ready = 1'b0;
    step("w_exc", S_RUN, 3'd0, 5'b00001, 3'b001, 1'b0);
    nop_inputs();
    step("halt_hlt", S_HALT, 3'd2, STL_ALL, 3'b000, 1'b0);

    n_checks++;
    if (halt_stat === 3'd2 && state === S_HALT) n_pass++;
    else $display("FAIL direct_halt_hlt: st=%0d hs=%0d", state, halt_stat);

    // retirement counter wrap at CNT_W=4
    do_reset_and_start();
    W_icode = 4'h6; E_icode = 4'h6;
    for (int i = 0; i < 20; i++) step("retire", S_RUN, 3'd0, STL_NONE, 3'b000, 1'b1);
    W_icode = 4'h1; m_stat = 3'd4;
    step("wrap_cc_gate", S_RUN, 3'd0, STL_NONE, 3'b001, 1'b0);
    nop_inputs();
    step("after_wrap", S_RUN, 3'd0, STL_NONE, 3'b000, 1'b0);

    @(negedge clk);
    #1;

    n_checks++;
    if (instr_cnt === 4'd4) n_pass++;
    else $display("FAIL direct_instr_wrap: ins=%0d expected 4", instr_cnt);

    n_checks++;
    if (state === S_RUN) n_pass++;
    else $display("FAIL direct_state_run: st=%0d", state);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    if (n_checks > 0 && n_pass == n_checks) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
